// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - state encodings and constants for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        FINAL = 2'd3
    } rd_state_t;

    typedef enum logic {
        WIDLE = 1'b0,
        WHIGH = 1'b1
    } wr_state_t;

    localparam int FETCH_BYTES = 3;
    localparam int DATA_BYTES  = 2;

    localparam logic [1:0] STARVE_LIMIT = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data-read and data-write ports of the memory arbiter
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                       iread_req;
    logic [15:0]                iread_addr;
    logic                       iread_gnt;
    logic [8*FETCH_BYTES-1:0]   iread_data;
    logic                       iread_valid;

    logic                       dread_req;
    logic [15:0]                dread_addr;
    logic                       dread_gnt;
    logic [8*DATA_BYTES-1:0]    dread_data;
    logic                       dread_valid;

    logic [15:0]                dwrite_addr;
    logic [15:0]                dwrite_data;
    logic [1:0]                 dwrite_en;
    logic                       dwrite_ready;

    modport master (
        output iread_req, iread_addr,
        input  iread_gnt, iread_data, iread_valid,
        output dread_req, dread_addr,
        input  dread_gnt, dread_data, dread_valid,
        output dwrite_addr, dwrite_data, dwrite_en,
        input  dwrite_ready
    );

    modport slave (
        input  iread_req, iread_addr,
        output iread_gnt, iread_data, iread_valid,
        input  dread_req, dread_addr,
        output dread_gnt, dread_data, dread_valid,
        input  dwrite_addr, dwrite_data, dwrite_en,
        output dwrite_ready
    );

endinterface

// File: rtl/dualportram.sv
// rtl/dualportram.sv - simple dual-port RAM, one synchronous write port and one registered read port
module dualportram #(
    parameter int addr_width = 15,
    parameter int data_width = 8
) (
    input  logic                  wclk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  rclk,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [2**addr_width];

    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first: a same-cycle write to raddr is not visible here.
    always_ff @(posedge rclk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one byte-wide dual-port RAM between fetch, data read and data write
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int addr_width = 15
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus
);

    rd_state_t             rd_state;
    wr_state_t             wr_state;
    logic [addr_width-1:0] rd_base;
    logic                  rd_fetch;
    logic [1:0]            starve_cnt;
    logic [7:0]            b0;
    logic [7:0]            b1;
    logic                  fwd_hit;
    logic [7:0]            fwd_byte;
    logic [addr_width-1:0] wr_hi_addr;
    logic [7:0]            wr_hi_byte;

    logic                  ram_we;
    logic [addr_width-1:0] ram_waddr;
    logic [7:0]            ram_wdata;
    logic [addr_width-1:0] ram_raddr;
    logic [7:0]            ram_rdata;
    logic [7:0]            cap;
    logic                  grant_i;
    logic                  grant_d;
    logic [addr_width-1:0] wr_addr_lo;
    logic [addr_width-1:0] wr_addr_hi;

    // Upper address bits alias onto the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.iread_addr, bus.dread_addr, bus.dwrite_addr};

    assign grant_i = (rd_state == IDLE) && bus.iread_req &&
                     (!bus.dread_req || (starve_cnt == STARVE_LIMIT));
    assign grant_d = (rd_state == IDLE) && bus.dread_req && !grant_i;

    assign bus.iread_gnt = grant_i;
    assign bus.dread_gnt = grant_d;

    assign cap        = fwd_hit ? fwd_byte : ram_rdata;
    assign wr_addr_lo = bus.dwrite_addr[addr_width-1:0];
    assign wr_addr_hi = wr_addr_lo + 1'b1;

    always_comb begin
        ram_raddr = rd_base;
        case (rd_state)
            IDLE:    ram_raddr = grant_d ? bus.dread_addr[addr_width-1:0]
                                         : bus.iread_addr[addr_width-1:0];
            BYTE1:   ram_raddr = rd_base + addr_width'(1);
            BYTE2:   ram_raddr = rd_base + addr_width'(2);
            default: ram_raddr = rd_base;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr_lo;
        ram_wdata = bus.dwrite_data[7:0];
        if (wr_state == WHIGH) begin
            ram_we    = 1'b1;
            ram_waddr = wr_hi_addr;
            ram_wdata = wr_hi_byte;
        end else begin
            case (bus.dwrite_en)
                2'b01, 2'b11: ram_we = 1'b1;
                2'b10: begin
                    ram_we    = 1'b1;
                    ram_waddr = wr_addr_hi;
                    ram_wdata = bus.dwrite_data[15:8];
                end
                default: ram_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state         <= WIDLE;
            bus.dwrite_ready <= 1'b1;
            wr_hi_addr       <= '0;
            wr_hi_byte       <= '0;
        end else begin
            case (wr_state)
                WIDLE: begin
                    if (bus.dwrite_en == 2'b11) begin
                        wr_state         <= WHIGH;
                        bus.dwrite_ready <= 1'b0;
                        wr_hi_addr       <= wr_addr_hi;
                        wr_hi_byte       <= bus.dwrite_data[15:8];
                    end
                end
                default: begin
                    wr_state         <= WIDLE;
                    bus.dwrite_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state        <= IDLE;
            rd_base         <= '0;
            rd_fetch        <= 1'b0;
            starve_cnt      <= '0;
            b0              <= '0;
            b1              <= '0;
            fwd_hit         <= 1'b0;
            fwd_byte        <= '0;
            bus.iread_data  <= '0;
            bus.dread_data  <= '0;
            bus.iread_valid <= 1'b0;
            bus.dread_valid <= 1'b0;
        end else begin
            bus.iread_valid <= 1'b0;
            bus.dread_valid <= 1'b0;

            if (!bus.iread_req || grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d) begin
                starve_cnt <= starve_cnt + 2'd1;
            end

            // Captured next cycle in place of the RAM's stale read-first output.
            fwd_hit  <= ram_we && (ram_waddr == ram_raddr);
            fwd_byte <= ram_wdata;

            case (rd_state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        rd_base  <= ram_raddr;
                        rd_fetch <= grant_i;
                        rd_state <= BYTE1;
                    end
                end
                BYTE1: begin
                    b0       <= cap;
                    rd_state <= rd_fetch ? BYTE2 : FINAL;
                end
                BYTE2: begin
                    b1       <= cap;
                    rd_state <= FINAL;
                end
                default: begin
                    if (rd_fetch) begin
                        bus.iread_data  <= {cap, b1, b0};
                        bus.iread_valid <= 1'b1;
                    end else begin
                        bus.dread_data  <= {cap, b0};
                        bus.dread_valid <= 1'b1;
                    end
                    rd_state <= IDLE;
                end
            endcase
        end
    end

    dualportram #(
        .addr_width (addr_width),
        .data_width (8)
    ) ram (
        .wclk  (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .rclk  (clk),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    mem_arbiter_if bus ();

    mem_arbiter #(.addr_width(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  en;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] en,
                            input string name);
        @(negedge clk);
        check({name, "_ready_before"}, 32'(bus.dwrite_ready), 32'd1);
        bus.dwrite_addr = addr;
        bus.dwrite_data = data;
        bus.dwrite_en   = en;
        @(negedge clk);
        bus.dwrite_en = 2'b00;
        if (en == 2'b11) begin
            check({name, "_ready_low"}, 32'(bus.dwrite_ready), 32'd0);
            @(negedge clk);
            check({name, "_ready_back"}, 32'(bus.dwrite_ready), 32'd1);
        end
    endtask

    task automatic do_read(input bit fetch, input logic [15:0] addr, input logic [23:0] exp,
                           input string name);
        int          w;
        int          vcyc;
        int          nval;
        logic [23:0] got;
        logic        g;
        @(negedge clk);
        if (fetch) begin
            bus.iread_req  = 1'b1;
            bus.iread_addr = addr;
        end else begin
            bus.dread_req  = 1'b1;
            bus.dread_addr = addr;
        end
        #1;
        g = fetch ? bus.iread_gnt : bus.dread_gnt;
        w = 0;
        while (!g && w < 20) begin
            @(negedge clk);
            #1;
            g = fetch ? bus.iread_gnt : bus.dread_gnt;
            w++;
        end
        check({name, "_gnt"}, 32'(g), 32'd1);
        @(negedge clk);
        bus.iread_req = 1'b0;
        bus.dread_req = 1'b0;
        vcyc = 0;
        nval = 0;
        got  = '0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (fetch ? bus.iread_valid : bus.dread_valid) begin
                nval++;
                vcyc = k;
                got  = fetch ? bus.iread_data : {8'h00, bus.dread_data};
            end
        end
        check({name, "_latency"}, 32'(vcyc), fetch ? 32'd4 : 32'd3);
        check({name, "_nvalid"}, 32'(nval), 32'd1);
        check({name, "_data"}, 32'(got), 32'(exp));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int        ngr;
        int        nd;
        int        ni;
        int        nv;
        bit        order [6];
        logic      gi;
        logic      gd;

        total  = 0;
        passed = 0;
        reset  = 1'b1;
        bus.iread_req   = 1'b0;
        bus.iread_addr  = '0;
        bus.dread_req   = 1'b0;
        bus.dread_addr  = '0;
        bus.dwrite_addr = '0;
        bus.dwrite_data = '0;
        bus.dwrite_en   = 2'b00;

        vecs[0]  = '{0, 16'h0100, 16'h0011, 2'b01, 24'h000000};
        vecs[1]  = '{0, 16'h0101, 16'h0022, 2'b01, 24'h000000};
        vecs[2]  = '{0, 16'h0102, 16'h0033, 2'b01, 24'h000000};
        vecs[3]  = '{2, 16'h0100, 16'h0000, 2'b00, 24'h332211};
        vecs[4]  = '{1, 16'h0101, 16'h0000, 2'b00, 24'h003322};
        vecs[5]  = '{0, 16'h7FFF, 16'h00AA, 2'b01, 24'h000000};
        vecs[6]  = '{0, 16'h0000, 16'h00BB, 2'b01, 24'h000000};
        vecs[7]  = '{1, 16'h7FFF, 16'h0000, 2'b00, 24'h00BBAA};
        vecs[8]  = '{0, 16'h7FFE, 16'hAACC, 2'b11, 24'h000000};
        vecs[9]  = '{2, 16'h7FFE, 16'h0000, 2'b00, 24'hBBAACC};
        vecs[10] = '{1, 16'h8100, 16'h0000, 2'b00, 24'h002211};
        vecs[11] = '{0, 16'h0300, 16'h0044, 2'b01, 24'h000000};
        vecs[12] = '{0, 16'h0300, 16'h5A99, 2'b10, 24'h000000};
        vecs[13] = '{1, 16'h0300, 16'h0000, 2'b00, 24'h005A44};
        vecs[14] = '{0, 16'hFFFF, 16'h1234, 2'b11, 24'h000000};
        vecs[15] = '{1, 16'h7FFF, 16'h0000, 2'b00, 24'h001234};

        repeat (3) @(negedge clk);
        check("rst_iread_data", 32'(bus.iread_data), 32'd0);
        check("rst_dread_data", 32'(bus.dread_data), 32'd0);
        check("rst_iread_valid", 32'(bus.iread_valid), 32'd0);
        check("rst_dread_valid", 32'(bus.dread_valid), 32'd0);
        check("rst_dwrite_ready", 32'(bus.dwrite_ready), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].kind == 0) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].en, $sformatf("vec%0d", i));
            end else begin
                do_read(vecs[i].kind == 2, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
            end
        end

        // Both requesters held: expect D,D,I,D,D,I.
        @(negedge clk);
        bus.iread_addr = 16'h0100;
        bus.dread_addr = 16'h0300;
        bus.iread_req  = 1'b1;
        bus.dread_req  = 1'b1;
        ngr = 0;
        nd  = 0;
        ni  = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (ngr == 6) begin
                bus.iread_req = 1'b0;
                bus.dread_req = 1'b0;
            end
            #1;
            if (bus.dread_valid) begin
                nd++;
                check($sformatf("arb_dvalid%0d_data", nd), 32'(bus.dread_data), 32'h5A44);
            end
            if (bus.iread_valid) begin
                ni++;
                check($sformatf("arb_ivalid%0d_data", ni), 32'(bus.iread_data), 32'h332211);
            end
            gi = bus.iread_gnt;
            gd = bus.dread_gnt;
            if ((gi || gd) && ngr < 6) begin
                order[ngr] = gi;
                ngr++;
            end
        end
        check("arb_ngrants", 32'(ngr), 32'd6);
        check("arb_order0", 32'(order[0]), 32'd0);
        check("arb_order1", 32'(order[1]), 32'd0);
        check("arb_order2", 32'(order[2]), 32'd1);
        check("arb_order3", 32'(order[3]), 32'd0);
        check("arb_order4", 32'(order[4]), 32'd0);
        check("arb_order5", 32'(order[5]), 32'd1);
        check("arb_ndvalid", 32'(nd), 32'd4);
        check("arb_nivalid", 32'(ni), 32'd2);

        // Two-byte write and data read of the same address in the same cycle.
        @(negedge clk);
        bus.dwrite_addr = 16'h0200;
        bus.dwrite_data = 16'hBEEF;
        bus.dwrite_en   = 2'b11;
        bus.dread_addr  = 16'h0200;
        bus.dread_req   = 1'b1;
        #1;
        check("fwd_gnt", 32'(bus.dread_gnt), 32'd1);
        check("fwd_ready_a", 32'(bus.dwrite_ready), 32'd1);
        @(negedge clk);
        bus.dwrite_en = 2'b00;
        bus.dread_req = 1'b0;
        check("fwd_ready_a1", 32'(bus.dwrite_ready), 32'd0);
        @(negedge clk);
        check("fwd_ready_a2", 32'(bus.dwrite_ready), 32'd1);
        check("fwd_novalid_a2", 32'(bus.dread_valid), 32'd0);
        @(negedge clk);
        check("fwd_valid_a3", 32'(bus.dread_valid), 32'd1);
        check("fwd_data", 32'(bus.dread_data), 32'hBEEF);
        @(negedge clk);
        check("fwd_valid_a4", 32'(bus.dread_valid), 32'd0);
        do_read(1'b0, 16'h0200, 24'h00BEEF, "fwd_reread");

        // Reset during a fetch and during the second byte of a two-byte write.
        do_write(16'h0401, 16'h0000, 2'b01, "rst_pre");
        @(negedge clk);
        bus.iread_addr = 16'h0100;
        bus.iread_req  = 1'b1;
        #1;
        check("rst_fetch_gnt", 32'(bus.iread_gnt), 32'd1);
        @(negedge clk);
        bus.iread_req   = 1'b0;
        bus.dwrite_addr = 16'h0400;
        bus.dwrite_data = 16'h7766;
        bus.dwrite_en   = 2'b11;
        @(negedge clk);
        bus.dwrite_en = 2'b00;
        check("rst_whigh_ready", 32'(bus.dwrite_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_iread_data", 32'(bus.iread_data), 32'd0);
        check("rst_mid_dread_data", 32'(bus.dread_data), 32'd0);
        check("rst_mid_ready", 32'(bus.dwrite_ready), 32'd1);
        nv = 0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) reset = 1'b0;
            if (bus.iread_valid) nv++;
        end
        check("rst_no_ivalid", 32'(nv), 32'd0);
        check("rst_after_iread_data", 32'(bus.iread_data), 32'd0);
        do_read(1'b1, 16'h0100, 24'h332211, "rst_refetch");
        do_read(1'b0, 16'h0400, 24'h000066, "rst_dropped_hi");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
